// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out framer family.
package sipo_pkg;

    typedef enum logic {
        StFill,
        StPend
    } state_e;

    // Width of a counter able to hold 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // LSB position of symbol slot idx inside the assembled word.
    function automatic int unsigned slot_lsb(input bit msb_first, input int unsigned sym_w,
                                             input int unsigned syms, input int unsigned idx);
        return msb_first ? (syms - 1 - idx) * sym_w : idx * sym_w;
    endfunction

endpackage

// File: rtl/sipo_framer_if.sv
// Serial symbol input and valid/ready word output of the framer.
interface sipo_framer_if
    import sipo_pkg::*;
#(
    parameter int unsigned SYM_W         = 2,
    parameter int unsigned SYMS_PER_WORD = 4
) ();

    localparam int unsigned W  = SYM_W * SYMS_PER_WORD;
    localparam int unsigned CW = cnt_w(SYMS_PER_WORD);

    logic             in_valid;
    logic [SYM_W-1:0] in_sym;
    logic             flush;
    logic             in_ready;
    logic             out_valid;
    logic [W-1:0]     out_word;
    logic [CW-1:0]    out_count;
    logic             out_ready;

    // Environment side: symbol source and word consumer.
    modport master (
        output in_valid, in_sym, flush, out_ready,
        input  in_ready, out_valid, out_word, out_count
    );

    // Framer side.
    modport slave (
        input  in_valid, in_sym, flush, out_ready,
        output in_ready, out_valid, out_word, out_count
    );

endinterface

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register for a word plus its symbol count.
module sipo_out_reg #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic [CW-1:0] cnt_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [CW-1:0] cnt_o
);

    logic          valid_d, valid_q;
    logic [DW-1:0] data_d, data_q;
    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        // A reload on the draining edge keeps valid high.
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            cnt_d   = cnt_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/sipo_framer.sv
// Accumulates SYMS_PER_WORD serial symbols into a word, with flush for partial words
// and back-pressure from a one-entry output holding register.
module sipo_framer
    import sipo_pkg::*;
#(
    parameter int unsigned SYM_W         = 2,
    parameter int unsigned SYMS_PER_WORD = 4,
    parameter bit          MSB_FIRST     = 1'b1
) (
    input logic           clk,
    input logic           reset,
    sipo_framer_if.slave  bus
);

    localparam int unsigned W  = SYM_W * SYMS_PER_WORD;
    localparam int unsigned CW = cnt_w(SYMS_PER_WORD);

    state_e        state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [W-1:0]  shreg_d, shreg_q;

    logic          accept;
    logic          close;
    logic          hold_free;
    logic          load;
    logic [CW-1:0] cnt_next;
    logic [W-1:0]  shreg_next;
    logic [W-1:0]  load_word;
    logic [CW-1:0] load_cnt;

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign bus.in_ready = (state_q == StFill) && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign hold_free    = !bus.out_valid || bus.out_ready;

    always_comb begin
        shreg_next = shreg_q;
        if (accept) begin
            for (int unsigned i = 0; i < SYMS_PER_WORD; i++) begin
                if (cnt_q == CW'(i)) begin
                    shreg_next[slot_lsb(MSB_FIRST, SYM_W, SYMS_PER_WORD, i) +: SYM_W] = bus.in_sym;
                end
            end
        end
    end

    assign cnt_next = cnt_q + CW'(accept);
    assign close    = bus.in_ready &&
                      ((accept && (cnt_next == CW'(SYMS_PER_WORD))) ||
                       (bus.flush && (cnt_next != '0)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        load      = 1'b0;
        load_word = shreg_next;
        load_cnt  = cnt_next;
        unique case (state_q)
            StFill: begin
                cnt_d   = cnt_next;
                shreg_d = shreg_next;
                if (close) begin
                    if (hold_free) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        shreg_d = '0;
                    end else begin
                        state_d = StPend;
                    end
                end
            end
            StPend: begin
                // Word is frozen in the shifter until the holding register frees up.
                load_word = shreg_q;
                load_cnt  = cnt_q;
                if (hold_free) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    shreg_d = '0;
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFill;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    sipo_out_reg #(
        .DW (W),
        .CW (CW)
    ) u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .data_i  (load_word),
        .cnt_i   (load_cnt),
        .ready_i (bus.out_ready),
        .valid_o (bus.out_valid),
        .data_o  (bus.out_word),
        .cnt_o   (bus.out_count)
    );

endmodule

// File: tb/tb_sipo_framer.sv
// Directed bench: MSB-first and LSB-first framers driven with identical stimulus.
module tb_sipo_framer;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    sipo_framer_if #(.SYM_W(2), .SYMS_PER_WORD(4)) bm ();
    sipo_framer_if #(.SYM_W(2), .SYMS_PER_WORD(4)) bl ();

    sipo_framer #(.SYM_W(2), .SYMS_PER_WORD(4), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (bm)
    );

    sipo_framer #(.SYM_W(2), .SYMS_PER_WORD(4), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic f, input logic r);
        bm.in_valid = v; bm.in_sym = s; bm.flush = f; bm.out_ready = r;
        bl.in_valid = v; bl.in_sym = s; bl.flush = f; bl.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks both framers: shared valid/count/ready, per-order word.
    task automatic chk_out(input string tag, input logic v, input logic [7:0] wm,
                           input logic [7:0] wl, input logic [2:0] c, input logic rdy);
        chk({tag, ".valid_m"}, 32'(bm.out_valid), 32'(v));
        chk({tag, ".valid_l"}, 32'(bl.out_valid), 32'(v));
        chk({tag, ".rdy_m"}, 32'(bm.in_ready), 32'(rdy));
        chk({tag, ".rdy_l"}, 32'(bl.in_ready), 32'(rdy));
        if (v) begin
            chk({tag, ".word_m"}, 32'(bm.out_word), 32'(wm));
            chk({tag, ".word_l"}, 32'(bl.out_word), 32'(wl));
            chk({tag, ".cnt_m"}, 32'(bm.out_count), 32'(c));
            chk({tag, ".cnt_l"}, 32'(bl.out_count), 32'(c));
        end
    endtask

    initial begin
        logic [1:0] syms8 [8];
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        #1;
        chk_out("reset", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        chk("reset.word_m", 32'(bm.out_word), 32'h0);
        chk("reset.cnt_l", 32'(bl.out_count), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset.rdy", 32'(bm.in_ready), 32'h1);

        // Full word, consumer always ready.
        drive(1'b1, 2'b01, 1'b0, 1'b1); tick();
        chk_out("w1.s0", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        drive(1'b1, 2'b10, 1'b0, 1'b1); tick();
        drive(1'b1, 2'b00, 1'b0, 1'b1); tick();
        chk_out("w1.s2", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        drive(1'b1, 2'b11, 1'b0, 1'b1); tick();
        chk_out("w1.word", 1'b1, 8'h63, 8'hC9, 3'd4, 1'b1);
        drive(1'b0, 2'b00, 1'b0, 1'b1); tick();
        chk_out("w1.one_cycle", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

        // Eight back-to-back symbols -> two words, no bubble.
        syms8 = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, syms8[i], 1'b0, 1'b1);
            tick();
            if (i == 3) chk_out("b2b.w0", 1'b1, 8'hE4, 8'h1B, 3'd4, 1'b1);
            else if (i == 7) chk_out("b2b.w1", 1'b1, 8'h1B, 8'hE4, 3'd4, 1'b1);
            else chk_out("b2b.mid", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1); tick();

        // Partial word via flush with no symbol; then an empty flush.
        drive(1'b1, 2'b01, 1'b0, 1'b1); tick();
        drive(1'b1, 2'b10, 1'b0, 1'b1); tick();
        drive(1'b0, 2'b00, 1'b1, 1'b1); tick();
        chk_out("flush.part", 1'b1, 8'h60, 8'h09, 3'd2, 1'b1);
        drive(1'b0, 2'b00, 1'b1, 1'b1); tick();
        chk_out("flush.empty", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        drive(1'b0, 2'b00, 1'b0, 1'b1); tick();
        chk_out("flush.idle", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

        // Back-pressure: consumer stalled across two words.
        syms8 = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, syms8[i], 1'b0, 1'b0);
            tick();
            if (i == 6) chk_out("bp.fill", 1'b1, 8'h1B, 8'hE4, 3'd4, 1'b1);
        end
        chk_out("bp.pend", 1'b1, 8'h1B, 8'hE4, 3'd4, 1'b0);
        drive(1'b1, 2'b01, 1'b0, 1'b0); tick();
        chk_out("bp.pend_hold", 1'b1, 8'h1B, 8'hE4, 3'd4, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b1); tick();
        chk_out("bp.swap", 1'b1, 8'hF0, 8'h0F, 3'd4, 1'b1);
        drive(1'b0, 2'b00, 1'b0, 1'b0); tick();
        chk_out("bp.held", 1'b1, 8'hF0, 8'h0F, 3'd4, 1'b1);
        drive(1'b0, 2'b00, 1'b0, 1'b1); tick();
        chk_out("bp.drained", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

        // Asynchronous reset with a held word and a partial word in flight.
        drive(1'b1, 2'b10, 1'b1, 1'b0); tick();
        chk_out("rst.flush1", 1'b1, 8'h80, 8'h02, 3'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_out("rst.async", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        chk("rst.word_m", 32'(bm.out_word), 32'h0);
        chk("rst.cnt_l", 32'(bl.out_count), 32'h0);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 1'b0, 1'b1);
            tick();
            if (i < 3) chk_out("rst.refill", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        end
        chk_out("rst.ff", 1'b1, 8'hFF, 8'hFF, 3'd4, 1'b1);
        drive(1'b0, 2'b00, 1'b0, 1'b1); tick();

        // Flush together with the completing symbol is a plain full word.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 2'b10, 1'b1, 1'b1); tick();
        chk_out("fl_full.word", 1'b1, 8'h56, 8'h95, 3'd4, 1'b1);
        drive(1'b0, 2'b00, 1'b0, 1'b1); tick();
        chk_out("fl_full.no_extra", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        tick();
        chk_out("fl_full.idle", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
